vc_fifo_bank: RTL and testbench

- Parametrised successor to the single-channel VC0 wrapper: NUM_VC independent virtual-channel FIFOs behind one shared write port.
- Each channel has its own read strobe, programmable almost-full/almost-empty thresholds, occupancy count and sticky error flag.
- Sits between the TC-to-VC mapper (write side) and the QoS arbiter (read side), and replaces per-VC instances.

---
 rtl/vc_fifo_bank.sv | 114 +++++++++++
 tb/tb_vc_fifo_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_bank
// Purpose  : NUM_VC independent virtual-channel FIFOs sharing one write port,
//            each with its own read strobe, occupancy count, programmable
//            almost-full/almost-empty thresholds and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo_bank #(
  parameter int BW     = 6,
  parameter int PTR_W  = 4,
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [VC_W-1:0]             wr_vc,
  input  logic [BW-1:0]               wr_data,
  input  logic [NUM_VC-1:0]           rd,
  input  logic                        err_clr,
  input  logic [NUM_VC*(PTR_W+1)-1:0] umbral_low,
  input  logic [NUM_VC*(PTR_W+1)-1:0] umbral_high,
  output logic [NUM_VC*BW-1:0]        data_out,
  output logic [NUM_VC-1:0]           data_valid,
  output logic [NUM_VC*(PTR_W+1)-1:0] count,
  output logic [NUM_VC-1:0]           full,
  output logic [NUM_VC-1:0]           empty,
  output logic [NUM_VC-1:0]           almost_full,
  output logic [NUM_VC-1:0]           almost_empty,
  output logic [NUM_VC-1:0]           error
);

  localparam int CW    = PTR_W + 1;
  localparam int DEPTH = 2 ** PTR_W;

  // Occupancy value meaning "every entry used"
  localparam logic [CW-1:0] c_full_cnt = {1'b1, {PTR_W{1'b0}}};

  // One FIFO per channel. The EMPTY/PARTIAL/FULL channel state is fully
  // captured by the registered count, so the flags double as the state.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic [BW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             error_q, error_d;
    logic             wr_hit, is_full, is_empty;
    logic             wr_ok, rd_ok, err_set;

    // Accept/reject decisions and next-state values for this channel
    always_comb begin
      is_full  = (count_q == c_full_cnt);
      is_empty = (count_q == '0);
      // Out-of-range wr_vc never matches any channel, so it is dropped
      wr_hit   = wr_valid && (wr_vc == VC_W'(i));
      // A same-cycle read frees a slot, so a full channel can still take data
      wr_ok    = wr_hit && (!is_full || rd[i]);
      rd_ok    = rd[i] && !is_empty;
      err_set  = (wr_hit && is_full && !rd[i]) || (rd[i] && is_empty);

      wptr_d   = wr_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d   = rd_ok ? rptr_q + 1'b1 : rptr_q;
      dout_d   = rd_ok ? mem[rptr_q] : dout_q;
      dvalid_d = rd_ok;

      count_d  = count_q;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

      // A fresh error outranks a simultaneous clear
      error_d  = error_q;
      if (err_set)      error_d = 1'b1;
      else if (err_clr) error_d = 1'b0;
    end

    // Control and output registers; reset empties the channel logically
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        count_q  <= '0;
        dout_q   <= '0;
        dvalid_q <= 1'b0;
        error_q  <= 1'b0;
      end else begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        count_q  <= count_d;
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
        error_q  <= error_d;
      end
    end

    // Storage array; contents are don't-care while count says empty
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr_q] <= wr_data;
    end

    assign data_out[i*BW +: BW] = dout_q;
    assign data_valid[i]        = dvalid_q;
    assign count[i*CW +: CW]    = count_q;
    assign error[i]             = error_q;
    assign full[i]              = is_full;
    assign empty[i]             = is_empty;
    assign almost_full[i]       = (count_q >= umbral_high[i*CW +: CW]);
    assign almost_empty[i]      = (count_q <= umbral_low[i*CW +: CW]);
  end : g_vc

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_fifo_bank
// Purpose  : Directed scoreboard bench for vc_fifo_bank (two channels, wide
//            channel select so out-of-range wr_vc values are reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_fifo_bank;

  localparam int BW     = 6;
  localparam int PTR_W  = 4;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 2;
  localparam int CW     = PTR_W + 1;

  logic                 clk;
  logic                 reset;
  logic                 wr_valid;
  logic [VC_W-1:0]      wr_vc;
  logic [BW-1:0]        wr_data;
  logic [NUM_VC-1:0]    rd;
  logic                 err_clr;
  logic [NUM_VC*CW-1:0] umbral_low;
  logic [NUM_VC*CW-1:0] umbral_high;
  logic [NUM_VC*BW-1:0] data_out;
  logic [NUM_VC-1:0]    data_valid;
  logic [NUM_VC*CW-1:0] count;
  logic [NUM_VC-1:0]    full;
  logic [NUM_VC-1:0]    empty;
  logic [NUM_VC-1:0]    almost_full;
  logic [NUM_VC-1:0]    almost_empty;
  logic [NUM_VC-1:0]    error;

  int n_pass  = 0;
  int n_total = 0;

  // Expected read data per channel, pushed when a read is issued
  logic [BW-1:0] exp0_q [$];
  logic [BW-1:0] exp1_q [$];

  vc_fifo_bank #(
    .BW(BW), .PTR_W(PTR_W), .NUM_VC(NUM_VC), .VC_W(VC_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_vc(wr_vc),
    .wr_data(wr_data), .rd(rd), .err_clr(err_clr),
    .umbral_low(umbral_low), .umbral_high(umbral_high),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] cnt(input int c);
    return count[c*CW +: CW];
  endfunction

  // Consume one rising edge; outputs are settled when this returns
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_vc    = VC_W'(ch);
    wr_data  = BW'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic push_exp(input int ch, input int d);
    if (ch == 0) exp0_q.push_back(BW'(d));
    else         exp1_q.push_back(BW'(d));
  endtask

  task automatic rdx(input int ch, input int d);
    rd[ch] = 1'b1;
    push_exp(ch, d);
    tick();
    rd = '0;
  endtask

  // Monitor: every data_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid[0]) begin
        if (exp0_q.size() == 0) check("vc0 unexpected data_valid", 32'(data_out[0 +: BW]), 32'hFFFF_FFFF);
        else check("vc0 read data", 32'(data_out[0 +: BW]), 32'(exp0_q.pop_front()));
      end
      if (data_valid[1]) begin
        if (exp1_q.size() == 0) check("vc1 unexpected data_valid", 32'(data_out[BW +: BW]), 32'hFFFF_FFFF);
        else check("vc1 read data", 32'(data_out[BW +: BW]), 32'(exp1_q.pop_front()));
      end
    end
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    wr_valid    = 1'b0;
    wr_vc       = '0;
    wr_data     = '0;
    rd          = '0;
    err_clr     = 1'b0;
    umbral_low  = {5'd2, 5'd2};
    umbral_high = {5'd14, 5'd14};
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("reset count", 32'(count), 0);
    check("reset empty", 32'(empty), 32'b11);
    check("reset full", 32'(full), 0);
    check("reset almost_empty", 32'(almost_empty), 32'b11);
    check("reset almost_full", 32'(almost_full), 0);
    check("reset error", 32'(error), 0);
    check("reset data_valid", 32'(data_valid), 0);

    // Fill vc0 with 1..16, watching the almost-full threshold
    for (int i = 1; i <= 16; i++) begin
      wr(0, i);
      if (i == 13) check("almost_full0 at 13", 32'(almost_full[0]), 0);
      if (i == 14) check("almost_full0 at 14", 32'(almost_full[0]), 1);
    end
    check("count0 full", 32'(cnt(0)), 16);
    check("full0", 32'(full[0]), 1);
    check("vc1 untouched count", 32'(cnt(1)), 0);
    check("vc1 untouched empty", 32'(empty[1]), 1);

    // Drain vc0 in order
    for (int i = 1; i <= 16; i++) rdx(0, i);
    tick();
    check("count0 drained", 32'(cnt(0)), 0);
    check("empty0 drained", 32'(empty[0]), 1);

    // Overflow, clear, simultaneous read+write on a full channel
    for (int i = 1; i <= 16; i++) wr(0, i);
    wr(0, 'h2A);
    check("overflow count0", 32'(cnt(0)), 16);
    check("overflow error0", 32'(error[0]), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr error0", 32'(error[0]), 0);
    rd[0] = 1'b1; push_exp(0, 1);
    wr(0, 'h15);
    rd = '0;
    check("full rd+wr count0", 32'(cnt(0)), 16);
    check("full rd+wr error0", 32'(error[0]), 0);
    // Overflow coinciding with err_clr: the new error must stick
    err_clr = 1'b1;
    wr(0, 'h2A);
    err_clr = 1'b0;
    check("set beats clear error0", 32'(error[0]), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int i = 2; i <= 16; i++) rdx(0, i);
    rdx(0, 'h15);
    tick();
    check("empty0 after 0x15", 32'(empty[0]), 1);

    // Underflow on vc1 with a same-cycle write that must still land
    rd[1] = 1'b1;
    wr(1, 'h07);
    rd = '0;
    check("underflow error1", 32'(error[1]), 1);
    check("underflow count1", 32'(cnt(1)), 1);
    check("underflow no data_valid1", 32'(data_valid[1]), 0);
    rdx(1, 'h07);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Interleaved writes plus an out-of-range channel select
    wr(0, 10); wr(1, 20); wr(0, 11); wr(1, 21); wr(0, 12);
    wr(3, 'h3F);
    check("bad vc count0", 32'(cnt(0)), 3);
    check("bad vc count1", 32'(cnt(1)), 2);
    check("bad vc error", 32'(error), 0);
    rd = 2'b11; push_exp(0, 10); push_exp(1, 20);
    tick();
    rd = '0;
    check("dual read data_valid", 32'(data_valid), 32'b11);
    rd = 2'b11; push_exp(0, 11); push_exp(1, 21);
    tick();
    rd = '0;
    rdx(0, 12);
    tick();
    check("interleave drained count", 32'(count), 0);

    // Asynchronous reset in the middle of a burst
    rd[1] = 1'b1; tick(); rd = '0;
    for (int i = 1; i <= 5; i++) wr(0, i);
    check("pre-reset count0", 32'(cnt(0)), 5);
    check("pre-reset error1", 32'(error[1]), 1);
    wr_valid = 1'b1; wr_vc = '0; wr_data = 6'd6;
    #2 reset = 1'b1;
    #1;
    check("async reset count", 32'(count), 0);
    check("async reset error", 32'(error), 0);
    check("async reset empty", 32'(empty), 32'b11);
    wr_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    wr(0, 'h11);
    check("post-reset count0", 32'(cnt(0)), 1);
    rdx(0, 'h11);
    repeat (3) tick();

    check("vc0 reads all returned", 32'(exp0_q.size()), 0);
    check("vc1 reads all returned", 32'(exp1_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
